// File: rtl/voice_allocator_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : voice_allocator_if
// Purpose  : Event handshake and per-voice output bundle of the voice
//            allocator.
//            master = event source / synthesizer side (drives events, reads
//                     voice outputs)
//            slave  = voice_allocator (accepts events, drives voice outputs)
// Signals  : ev_valid/ev_ready handshake, ev_note_on, ev_note[6:0],
//            ev_velocity[6:0], ev_freq[31:0], all_notes_off,
//            frequencies[N][31:0], voice_volumes[N][31:0],
//            active_mask[N], dropped
// Revision : 1.0  initial release
// ============================================================================
interface voice_allocator_if #(
  parameter int N_VOICES = 8
);
  logic                         ev_valid;
  logic                         ev_ready;
  logic                         ev_note_on;
  logic [6:0]                   ev_note;
  logic [6:0]                   ev_velocity;
  logic [31:0]                  ev_freq;
  logic                         all_notes_off;
  logic [N_VOICES-1:0][31:0]    frequencies;
  logic [N_VOICES-1:0][31:0]    voice_volumes;
  logic [N_VOICES-1:0]          active_mask;
  logic                         dropped;

  modport master (
    output ev_valid, ev_note_on, ev_note, ev_velocity, ev_freq, all_notes_off,
    input  ev_ready, frequencies, voice_volumes, active_mask, dropped
  );

  modport slave (
    input  ev_valid, ev_note_on, ev_note, ev_velocity, ev_freq, all_notes_off,
    output ev_ready, frequencies, voice_volumes, active_mask, dropped
  );
endinterface
`default_nettype wire

// File: rtl/voice_allocator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : voice_allocator
// Purpose  : Converts note-on/note-off events into steady per-voice frequency
//            and volume values. Handles voice assignment (retrigger, free
//            voice, round-robin steal) and a linear attack/release ramp.
// Ports    : clk      - system clock
//            reset_n  - asynchronous reset, active low
//            bus      - voice_allocator_if.slave (event handshake in,
//                       frequencies/voice_volumes/active_mask/dropped out)
// Revision : 1.0  initial release
// ============================================================================
module voice_allocator #(
  parameter int N_VOICES     = 8,
  parameter int DEFAULT_FREQ = 440,
  parameter int RAMP_DIV     = 1024,
  parameter int RAMP_STEP    = 4
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  voice_allocator_if.slave    bus
);

  localparam int         c_PTR_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam int         c_CNT_W = $clog2(RAMP_DIV);
  localparam logic [7:0] c_STEP  = 8'(RAMP_STEP);

  typedef enum logic [1:0] {V_FREE, V_ATTACK, V_HOLD, V_RELEASE} voice_state_t;
  typedef enum logic       {S_IDLE, S_APPLY} ctrl_state_t;

  // Control path
  ctrl_state_t          r_cs;
  logic                 r_ev_on;
  logic [6:0]           r_ev_note;
  logic [6:0]           r_ev_vel;
  logic [31:0]          r_ev_freq;
  logic [c_PTR_W-1:0]   r_steal_ptr;
  logic                 r_drop;
  logic [c_CNT_W-1:0]   r_ramp_cnt;

  // Per-voice state (outputs are a registered copy of these)
  voice_state_t         r_vstate  [N_VOICES];
  logic [6:0]           r_vnote   [N_VOICES];
  logic [31:0]          r_vfreq   [N_VOICES];
  logic [7:0]           r_vvol    [N_VOICES];
  logic [7:0]           r_vtarget [N_VOICES];

  logic                 w_tick;
  logic                 w_is_on;
  logic                 w_apply;
  logic                 w_apply_on;
  logic                 w_apply_off;
  logic                 w_drop_now;
  logic                 w_hit_found;
  logic [c_PTR_W-1:0]   w_hit_idx;
  logic                 w_free_found;
  logic [c_PTR_W-1:0]   w_free_idx;
  logic [N_VOICES-1:0]  w_off_mask;
  logic                 w_use_steal;
  logic [c_PTR_W-1:0]   w_sel_idx;
  voice_state_t         w_nstate [N_VOICES];
  logic [7:0]           w_nvol   [N_VOICES];

  assign w_tick = (r_ramp_cnt == c_CNT_W'(RAMP_DIV - 1));

  // A note-on with zero velocity behaves exactly like a note-off.
  assign w_is_on     = r_ev_on && (r_ev_vel != 7'd0);
  assign w_apply     = (r_cs == S_APPLY) && !bus.all_notes_off;
  assign w_apply_on  = w_apply && w_is_on && (r_ev_freq != 32'd0);
  assign w_apply_off = w_apply && !w_is_on;
  assign w_drop_now  = ((r_cs == S_APPLY) && bus.all_notes_off)
                     || (w_apply && w_is_on && (r_ev_freq == 32'd0))
                     || (w_apply_off && (w_off_mask == '0));

  assign w_use_steal = !w_hit_found && !w_free_found;
  assign w_sel_idx   = w_hit_found  ? w_hit_idx  :
                       w_free_found ? w_free_idx : r_steal_ptr;

  // Voice search: scanning from the top down lets the lowest index win.
  always_comb begin
    w_hit_found  = 1'b0;
    w_hit_idx    = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_off_mask   = '0;
    for (int v = N_VOICES - 1; v >= 0; v--) begin
      if (r_vstate[v] != V_FREE && r_vnote[v] == r_ev_note) begin
        w_hit_found = 1'b1;
        w_hit_idx   = c_PTR_W'(v);
      end
      if (r_vstate[v] == V_FREE) begin
        w_free_found = 1'b1;
        w_free_idx   = c_PTR_W'(v);
      end
      if ((r_vstate[v] == V_ATTACK || r_vstate[v] == V_HOLD) && r_vnote[v] == r_ev_note) begin
        w_off_mask[v] = 1'b1;
      end
    end
  end

  // Next ramp value per voice; arithmetic is clamped so it never wraps.
  always_comb begin
    for (int v = 0; v < N_VOICES; v++) begin
      w_nvol[v]   = r_vvol[v];
      w_nstate[v] = r_vstate[v];
      case (r_vstate[v])
        V_ATTACK: begin
          if (r_vvol[v] < r_vtarget[v]) begin
            if (({1'b0, r_vvol[v]} + {1'b0, c_STEP}) >= {1'b0, r_vtarget[v]})
              w_nvol[v] = r_vtarget[v];
            else
              w_nvol[v] = r_vvol[v] + c_STEP;
          end else if (r_vvol[v] > r_vtarget[v]) begin
            // Retrigger/steal with a lower target glides down to it.
            if ((r_vvol[v] - r_vtarget[v]) <= c_STEP)
              w_nvol[v] = r_vtarget[v];
            else
              w_nvol[v] = r_vvol[v] - c_STEP;
          end
          w_nstate[v] = (w_nvol[v] == r_vtarget[v]) ? V_HOLD : V_ATTACK;
        end
        V_RELEASE: begin
          w_nvol[v]   = (r_vvol[v] <= c_STEP) ? 8'd0 : (r_vvol[v] - c_STEP);
          w_nstate[v] = (w_nvol[v] == 8'd0) ? V_FREE : V_RELEASE;
        end
        V_FREE:  w_nvol[v] = 8'd0;
        default: w_nvol[v] = r_vvol[v];
      endcase
    end
  end

  // Free-running ramp tick divider.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_ramp_cnt <= '0;
    else if (w_tick)
      r_ramp_cnt <= '0;
    else
      r_ramp_cnt <= r_ramp_cnt + c_CNT_W'(1);
  end

  // Control FSM: latch in IDLE, apply in APPLY (one event per two clocks).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs        <= S_IDLE;
      bus.ev_ready <= 1'b0;
      r_ev_on     <= 1'b0;
      r_ev_note   <= '0;
      r_ev_vel    <= '0;
      r_ev_freq   <= '0;
      r_steal_ptr <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_drop <= w_drop_now;
      case (r_cs)
        S_IDLE: begin
          bus.ev_ready <= 1'b1;
          if (bus.ev_valid && bus.ev_ready) begin
            r_ev_on      <= bus.ev_note_on;
            r_ev_note    <= bus.ev_note;
            r_ev_vel     <= bus.ev_velocity;
            r_ev_freq    <= bus.ev_freq;
            r_cs         <= S_APPLY;
            bus.ev_ready <= 1'b0;
          end
        end
        S_APPLY: begin
          r_cs         <= S_IDLE;
          bus.ev_ready <= 1'b1;
        end
      endcase
      if (w_apply_on && w_use_steal)
        r_steal_ptr <= (r_steal_ptr == c_PTR_W'(N_VOICES - 1)) ? '0
                                                               : r_steal_ptr + c_PTR_W'(1);
    end
  end

  // Voice state. Priority: all_notes_off, event apply, ramp tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int v = 0; v < N_VOICES; v++) begin
        r_vstate[v]  <= V_FREE;
        r_vnote[v]   <= '0;
        r_vfreq[v]   <= 32'(DEFAULT_FREQ);
        r_vvol[v]    <= '0;
        r_vtarget[v] <= '0;
      end
    end else begin
      for (int v = 0; v < N_VOICES; v++) begin
        if (bus.all_notes_off) begin
          if (r_vstate[v] != V_FREE)
            r_vstate[v] <= V_RELEASE;
        end else if (w_apply_on && w_sel_idx == c_PTR_W'(v)) begin
          // Volume is kept so a retrigger/steal ramps from where it is.
          r_vnote[v]   <= r_ev_note;
          r_vfreq[v]   <= r_ev_freq;
          r_vtarget[v] <= {r_ev_vel, 1'b1};
          r_vstate[v]  <= V_ATTACK;
        end else if (w_apply_off && w_off_mask[v]) begin
          r_vstate[v] <= V_RELEASE;
        end else if (w_tick) begin
          r_vvol[v]   <= w_nvol[v];
          r_vstate[v] <= w_nstate[v];
        end
      end
    end
  end

  // Registered output stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int v = 0; v < N_VOICES; v++) begin
        bus.frequencies[v]   <= 32'(DEFAULT_FREQ);
        bus.voice_volumes[v] <= '0;
      end
      bus.active_mask <= '0;
      bus.dropped     <= 1'b0;
    end else begin
      for (int v = 0; v < N_VOICES; v++) begin
        bus.frequencies[v]   <= r_vfreq[v];
        bus.voice_volumes[v] <= {24'd0, r_vvol[v]};
        bus.active_mask[v]   <= (r_vstate[v] != V_FREE);
      end
      bus.dropped <= r_drop;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_voice_allocator
// Purpose  : Directed self-checking bench for voice_allocator (fast ramp:
//            RAMP_DIV=4, RAMP_STEP=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_voice_allocator;
  localparam int N = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   errors  = 0;
  int   checks  = 0;

  always #5 clk = ~clk;

  voice_allocator_if #(.N_VOICES(N)) bus ();

  voice_allocator #(
    .N_VOICES(N), .DEFAULT_FREQ(440), .RAMP_DIV(4), .RAMP_STEP(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // Drives one event and returns 1ns after its accept edge.
  task automatic send_event(input bit on, input logic [6:0] note, input logic [6:0] vel,
                            input logic [31:0] f, input bit anoff);
    int n = 0;
    @(negedge clk);
    while (bus.ev_ready !== 1'b1) begin
      n++;
      if (n > 20) begin
        $display("FAIL send_event_ready actual=%0b required=1", bus.ev_ready);
        $fatal(1, "event handshake stalled");
      end
      @(negedge clk);
    end
    bus.ev_valid = 1'b1; bus.ev_note_on = on; bus.ev_note = note;
    bus.ev_velocity = vel; bus.ev_freq = f; bus.all_notes_off = anoff;
    @(posedge clk); #1;
    bus.ev_valid = 1'b0; bus.all_notes_off = 1'b0;
  endtask

  // From 1ns after an accept edge, move to the sample point after edge +2.
  task automatic settle();
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_all_off();
    @(negedge clk); bus.all_notes_off = 1'b1;
    @(negedge clk); bus.all_notes_off = 1'b0;
  endtask

  task automatic test_reset();
    logic [N-1:0][31:0] exp_f;
    for (int v = 0; v < N; v++) exp_f[v] = 32'd440;
    #1 reset_n = 1'b0;
    #20;
    checks++; if (bus.ev_ready !== 1'b0) begin errors++; $display("FAIL reset_ready actual=%0b required=0", bus.ev_ready); end
    checks++; if (bus.frequencies !== exp_f) begin errors++; $display("FAIL reset_freq actual=%h required=%h", bus.frequencies, exp_f); end
    checks++; if (bus.voice_volumes !== '0) begin errors++; $display("FAIL reset_vol actual=%h required=0", bus.voice_volumes); end
    checks++; if (bus.active_mask !== 8'h00) begin errors++; $display("FAIL reset_mask actual=%h required=00", bus.active_mask); end
    checks++; if (bus.dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped actual=%0b required=0", bus.dropped); end
    #1 reset_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.ev_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release actual=%0b required=1", bus.ev_ready); end
  endtask

  task automatic test_note_on();
    int prev, cur, bad;
    send_event(1'b1, 7'd60, 7'd127, 32'd262, 1'b0);
    @(posedge clk); @(negedge clk);
    checks++; if (bus.frequencies[0] !== 32'd440) begin errors++; $display("FAIL noteon_edge1_freq actual=%0d required=440", bus.frequencies[0]); end
    @(posedge clk); @(negedge clk);
    checks++; if (bus.frequencies[0] !== 32'd262) begin errors++; $display("FAIL noteon_freq actual=%0d required=262", bus.frequencies[0]); end
    checks++; if (bus.active_mask !== 8'h01) begin errors++; $display("FAIL noteon_mask actual=%h required=01", bus.active_mask); end
    checks++; if (bus.voice_volumes[0] !== 32'd0) begin errors++; $display("FAIL noteon_vol_start actual=%0d required=0", bus.voice_volumes[0]); end
    prev = 0; bad = 0;
    for (int c = 0; c < 400; c++) begin
      if (prev == 255) break;
      @(negedge clk);
      cur = int'(bus.voice_volumes[0]);
      if (cur != prev) begin
        if (cur != ((prev + 4 > 255) ? 255 : prev + 4)) bad++;
        prev = cur;
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL attack_steps bad_steps=%0d required=0", bad); end
    checks++; if (prev !== 255) begin errors++; $display("FAIL attack_peak actual=%0d required=255", prev); end
    repeat (20) @(negedge clk);
    checks++; if (bus.voice_volumes[0] !== 32'd255) begin errors++; $display("FAIL hold_vol actual=%0d required=255", bus.voice_volumes[0]); end
  endtask

  task automatic test_steal();
    int vi;
    for (int n = 61; n <= 67; n++) send_event(1'b1, 7'(n), 7'd127, 32'(1000 + n), 1'b0);
    settle();
    checks++; if (bus.active_mask !== 8'hFF) begin errors++; $display("FAIL steal_full_mask actual=%h required=ff", bus.active_mask); end
    for (int i = 0; i < 9; i++) begin
      vi = i % 8;
      send_event(1'b1, 7'(68 + i), (i == 0) ? 7'd64 : 7'd127, 32'(1068 + i), 1'b0);
      settle();
      checks++;
      if (bus.frequencies[vi] !== 32'(1068 + i)) begin
        errors++; $display("FAIL steal_%0d_freq voice=%0d actual=%0d required=%0d", i, vi, bus.frequencies[vi], 1068 + i);
      end
      if (i == 0) begin
        checks++; if (bus.voice_volumes[0] !== 32'd255) begin errors++; $display("FAIL steal_vol_kept actual=%0d required=255", bus.voice_volumes[0]); end
      end
      if (i == 1) begin
        checks++; if (bus.frequencies[0] !== 32'd1068) begin errors++; $display("FAIL steal_ptr_advance v0=%0d required=1068", bus.frequencies[0]); end
      end
    end
    checks++; if (bus.frequencies[7] !== 32'd1075) begin errors++; $display("FAIL steal_v7 actual=%0d required=1075", bus.frequencies[7]); end
    pulse_all_off();
    for (int c = 0; c < 800 && bus.active_mask != 8'h00; c++) @(negedge clk);
    checks++; if (bus.active_mask !== 8'h00) begin errors++; $display("FAIL steal_cleanup_mask actual=%h required=00", bus.active_mask); end
  endtask

  task automatic test_release();
    int prev, cur, bad;
    send_event(1'b1, 7'd60, 7'd127, 32'd262, 1'b0);
    for (int c = 0; c < 400 && bus.voice_volumes[0] != 32'd255; c++) @(negedge clk);
    checks++; if (bus.voice_volumes[0] !== 32'd255) begin errors++; $display("FAIL release_pre_peak actual=%0d required=255", bus.voice_volumes[0]); end
    send_event(1'b0, 7'd60, 7'd0, 32'd0, 1'b0);
    settle();
    checks++; if (bus.voice_volumes[0] !== 32'd255 || bus.active_mask !== 8'h01) begin
      errors++; $display("FAIL release_start vol=%0d mask=%h required vol=255 mask=01", bus.voice_volumes[0], bus.active_mask);
    end
    prev = 255; bad = 0;
    for (int c = 0; c < 400 && bus.active_mask[0]; c++) begin
      @(negedge clk);
      cur = int'(bus.voice_volumes[0]);
      if (cur != prev) begin
        if (cur != ((prev < 4) ? 0 : prev - 4)) bad++;
        prev = cur;
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL release_steps bad_steps=%0d required=0", bad); end
    checks++; if (bus.voice_volumes[0] !== 32'd0 || bus.active_mask !== 8'h00) begin
      errors++; $display("FAIL release_end vol=%0d mask=%h required vol=0 mask=00", bus.voice_volumes[0], bus.active_mask);
    end
    checks++; if (bus.frequencies[0] !== 32'd262) begin errors++; $display("FAIL release_freq_kept actual=%0d required=262", bus.frequencies[0]); end
  endtask

  task automatic test_dropped();
    logic [6:0]  ev_note [3] = '{7'd70, 7'd70, 7'd71};
    logic [6:0]  ev_vel  [3] = '{7'd0,  7'd0,  7'd50};
    logic        ev_on   [3] = '{1'b0,  1'b1,  1'b1};
    logic [31:0] ev_f    [3] = '{32'd0, 32'd500, 32'd0};
    for (int i = 0; i < 3; i++) begin
      send_event(ev_on[i], ev_note[i], ev_vel[i], ev_f[i], 1'b0);
      settle();
      checks++; if (bus.dropped !== 1'b1) begin errors++; $display("FAIL drop_%0d_pulse actual=%0b required=1", i, bus.dropped); end
      @(negedge clk);
      checks++; if (bus.dropped !== 1'b0) begin errors++; $display("FAIL drop_%0d_single actual=%0b required=0", i, bus.dropped); end
    end
    checks++; if (bus.active_mask !== 8'h00) begin errors++; $display("FAIL drop_no_voice actual=%h required=00", bus.active_mask); end
    send_event(1'b1, 7'd62, 7'd100, 32'd294, 1'b0);
    settle();
    checks++; if (bus.dropped !== 1'b0 || bus.frequencies[0] !== 32'd294) begin
      errors++; $display("FAIL vel0_setup dropped=%0b freq=%0d required dropped=0 freq=294", bus.dropped, bus.frequencies[0]);
    end
    send_event(1'b1, 7'd62, 7'd0, 32'd294, 1'b0);
    settle();
    checks++; if (bus.dropped !== 1'b0) begin errors++; $display("FAIL vel0_release_dropped actual=%0b required=0", bus.dropped); end
    for (int c = 0; c < 400 && bus.active_mask != 8'h00; c++) @(negedge clk);
    checks++; if (bus.active_mask !== 8'h00) begin errors++; $display("FAIL vel0_release_free actual=%h required=00", bus.active_mask); end
  endtask

  task automatic test_anoff_apply();
    send_event(1'b1, 7'd60, 7'd127, 32'd262, 1'b0);
    send_event(1'b1, 7'd61, 7'd127, 32'd277, 1'b0);
    repeat (300) @(negedge clk);
    send_event(1'b1, 7'd64, 7'd127, 32'd330, 1'b0);
    bus.all_notes_off = 1'b1;           // lands in the APPLY cycle
    @(posedge clk); #1 bus.all_notes_off = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (bus.dropped !== 1'b1) begin errors++; $display("FAIL anoff_dropped actual=%0b required=1", bus.dropped); end
    checks++; if (bus.frequencies[2] !== 32'd1070) begin errors++; $display("FAIL anoff_discard_freq actual=%0d required=1070", bus.frequencies[2]); end
    checks++; if (bus.active_mask !== 8'h03) begin errors++; $display("FAIL anoff_mask actual=%h required=03", bus.active_mask); end
    for (int c = 0; c < 600 && bus.active_mask != 8'h00; c++) @(negedge clk);
    checks++; if (bus.active_mask !== 8'h00) begin errors++; $display("FAIL anoff_release_all actual=%h required=00", bus.active_mask); end
  endtask

  task automatic test_anoff_idle();
    send_event(1'b1, 7'd65, 7'd127, 32'd1234, 1'b1);
    settle();
    checks++; if (bus.frequencies[0] !== 32'd1234 || bus.active_mask !== 8'h01 || bus.dropped !== 1'b0) begin
      errors++; $display("FAIL anoff_idle_accept freq=%0d mask=%h dropped=%0b required 1234/01/0",
                         bus.frequencies[0], bus.active_mask, bus.dropped);
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0][31:0] exp_f;
    for (int v = 0; v < N; v++) exp_f[v] = 32'd440;
    send_event(1'b1, 7'd67, 7'd127, 32'd600, 1'b0);
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    bus.ev_valid = 1'b1; bus.ev_note_on = 1'b1; bus.ev_note = 7'd66;
    bus.ev_velocity = 7'd100; bus.ev_freq = 32'd555;
    #1;
    checks++; if (bus.frequencies !== exp_f) begin errors++; $display("FAIL midreset_freq actual=%h required=%h", bus.frequencies, exp_f); end
    checks++; if (bus.voice_volumes !== '0 || bus.active_mask !== 8'h00) begin
      errors++; $display("FAIL midreset_vol_mask vol=%h mask=%h required 0/00", bus.voice_volumes, bus.active_mask);
    end
    checks++; if (bus.ev_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready actual=%0b required=0", bus.ev_ready); end
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.ev_ready !== 1'b1) begin errors++; $display("FAIL postreset_ready actual=%0b required=1", bus.ev_ready); end
    @(posedge clk); #1 bus.ev_valid = 1'b0;   // accept edge
    settle();
    checks++; if (bus.frequencies[0] !== 32'd555 || bus.active_mask !== 8'h01) begin
      errors++; $display("FAIL postreset_event freq=%0d mask=%h required 555/01", bus.frequencies[0], bus.active_mask);
    end
  endtask

  initial begin
    bus.ev_valid = 1'b0; bus.ev_note_on = 1'b0; bus.ev_note = '0;
    bus.ev_velocity = '0; bus.ev_freq = '0; bus.all_notes_off = 1'b0;
    test_reset();
    test_note_on();
    test_steal();
    test_release();
    test_dropped();
    test_anoff_apply();
    test_anoff_idle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
